mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the EX/MEM pipeline register outputs.
- Drives a req/ack data-memory bus for loads and stores, and stalls upstream stages while an access is outstanding.
- Registers the MEM/WB pipeline outputs for writeback.
- Handles misaligned addresses and bus timeouts by injecting a flagged bubble.

Parameters:
- MAX_WAIT, 16: number of REQ cycles without mem_ack before the access is abandoned (minimum 1).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- syscall_m  in  1  syscall flag from EX/MEM
- reg_write_m  in  1  register-write enable from EX/MEM
- mem_to_reg_m  in  1  load indicator from EX/MEM
- mem_write_m  in  1  store indicator from EX/MEM
- alu_out_m  in  32  ALU result / memory address
- write_data_m  in  32  store data
- write_reg_m  in  5  destination register
- instr_m  in  32  instruction word
- stall_m  out  1  hold EX/MEM and earlier stages
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_ack  in  1  bus completion
- mem_rdata  in  32  bus read data, valid with mem_ack
- syscall_w  out  1  MEM/WB syscall
- reg_write_w  out  1  MEM/WB register-write enable
- mem_to_reg_w  out  1  MEM/WB load indicator
- read_data_w  out  32  loaded data
- alu_out_w  out  32  ALU result
- write_reg_w  out  5  destination register
- instr_w  out  32  instruction word
- misaligned_w  out  1  one-cycle flag: the instruction in W was a dropped misaligned access
- timeout_err  out  1  one-cycle flag: the instruction in W was an access that timed out

Behaviour:
- Reset: async on rst_n low. All outputs are 0, the FSM is in IDLE, the wait counter is 0, and mem_req drops immediately, including mid-access.
- Memory op: mem_op = mem_to_reg_m | mem_write_m. Alignment: aligned = (alu_out_m[1:0] == 0).
- FSM has two states, IDLE and REQ.
- IDLE, non-mem op:
  - stall_m = 0.
  - Next edge: the W registers load the M inputs, read_data_w = 0, both flags = 0.
- IDLE, mem op, aligned:
  - stall_m = 1 (combinational).
  - Next edge: latch mem_addr = alu_out_m, mem_wdata = write_data_m, mem_we = mem_write_m; set mem_req = 1; enter REQ.
  - W loads a bubble.
- IDLE, mem op, misaligned:
  - No bus access, stall_m = 0.
  - Next edge: W loads a bubble with misaligned_w = 1 and instr_w = instr_m.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - stall_m = !mem_ack.
  - The counter increments on each cycle without ack.
- REQ with mem_ack on an edge:
  - W loads the M inputs, and read_data_w = mem_rdata if it is a load, else 0.
  - mem_req = 0, counter cleared, return to IDLE.
- REQ with counter == MAX_WAIT-1 and no ack on an edge:
  - mem_req = 0, stall_m released that cycle.
  - W loads a bubble with timeout_err = 1 and instr_w = instr_m.
  - Return to IDLE.
- Bubble definition: syscall_w = reg_write_w = mem_to_reg_w = 0, read_data_w = alu_out_w = 0, write_reg_w = 0. instr_w = 0 unless a flag is set.
- Flags are single-cycle pulses; they clear on the next edge.
- M inputs are held stable by the upstream stall while in REQ. The controller reads them live and does not re-sample.
- Timing:
  - Minimum memory-op stall is 1 cycle (ack in the first REQ cycle).
  - Latency from M to W is 1 + (number of REQ cycles).
  - Non-mem ops have a throughput of 1 per cycle.
- mem_ack in IDLE is ignored. mem_ack on the timeout edge counts as a normal completion, not an error.
- Counter width is $clog2(MAX_WAIT+1). It never wraps; it saturates at abort.

Test Plan:
- Reset mid-REQ (mem_req = 1, rst_n low) -> mem_req = 0 and stall_m = 0 immediately; all W outputs 0; FSM in IDLE after release.
- ALU op: alu_out_m = 0x00001234, reg_write_m = 1, write_reg_m = 5 -> next edge alu_out_w = 0x1234, write_reg_w = 5, reg_write_w = 1; mem_req never asserted; stall_m = 0.
- Load: addr 0x100, mem_ack on the 3rd REQ cycle with mem_rdata = 0xDEADBEEF.
  - stall_m high 3 cycles, mem_req high 3 cycles, mem_we = 0.
  - Bubbles in W during the stall.
  - Then read_data_w = 0xDEADBEEF, mem_to_reg_w = 1.
- Store: addr 0x204, write_data_m = 0x55, ack in the first REQ cycle -> mem_we = 1, mem_wdata = 0x55, stall_m for 1 cycle, reg_write_w = 0.
- Misaligned load at addr 0x102 -> no mem_req; next cycle misaligned_w = 1 for exactly 1 cycle, reg_write_w = 0, stall_m never high.
- Timeout with MAX_WAIT = 4, never ack -> mem_req high 4 cycles, then timeout_err = 1 for 1 cycle, stall_m drops, and the next ALU op passes normally.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs loads/stores over a req/ack bus, stalls upstream while
// an access is outstanding, and registers MEM/WB outputs (flagged bubbles on error).
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic              mem_write_m,
    input  logic [31:0]       alu_out_m,
    input  logic [31:0]       write_data_m,
    input  logic [4:0]        write_reg_m,
    input  logic [31:0]       instr_m,
    output logic              stall_m,
    mem_stage_ctrl_if.master  bus,
    output logic              syscall_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic [31:0]       read_data_w,
    output logic [31:0]       alu_out_w,
    output logic [4:0]        write_reg_w,
    output logic [31:0]       instr_w,
    output logic              misaligned_w,
    output logic              timeout_err
);

    localparam int unsigned          CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic        syscall;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
        logic [31:0] instr;
        logic        misaligned;
        logic        timeout;
    } wb_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    wb_t              wb_q, wb_d;
    wb_t              wb_pass;
    logic             stall_c;
    logic             mem_op;
    logic             aligned;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        mem_op  = mem_to_reg_m | mem_write_m;
        aligned = (alu_out_m[1:0] == 2'b00);

        wb_pass            = '0;
        wb_pass.syscall    = syscall_m;
        wb_pass.reg_write  = reg_write_m;
        wb_pass.mem_to_reg = mem_to_reg_m;
        wb_pass.alu_out    = alu_out_m;
        wb_pass.write_reg  = write_reg_m;
        wb_pass.instr      = instr_m;

        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wb_d    = '0;
        stall_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    wb_d = wb_pass;
                end else if (aligned) begin
                    stall_c = 1'b1;
                    addr_d  = alu_out_m;
                    wdata_d = write_data_m;
                    we_d    = mem_write_m;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    wb_d.instr      = instr_m;
                    wb_d.misaligned = 1'b1;
                end
            end
            REQ: begin
                // An ack on the final wait cycle still completes the access normally.
                if (bus.mem_ack) begin
                    wb_d           = wb_pass;
                    wb_d.read_data = mem_to_reg_m ? bus.mem_rdata : 32'h0;
                    req_d          = 1'b0;
                    cnt_d          = '0;
                    state_d        = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_d.instr   = instr_m;
                    wb_d.timeout = 1'b1;
                    req_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb_q    <= wb_d;
        end
    end

    // Held in reset, the stall must read 0 even though the M inputs may still show a load.
    assign stall_m       = rst_n & stall_c;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign syscall_w    = wb_q.syscall;
    assign reg_write_w  = wb_q.reg_write;
    assign mem_to_reg_w = wb_q.mem_to_reg;
    assign read_data_w  = wb_q.read_data;
    assign alu_out_w    = wb_q.alu_out;
    assign write_reg_w  = wb_q.write_reg;
    assign instr_w      = wb_q.instr;
    assign misaligned_w = wb_q.misaligned;
    assign timeout_err  = wb_q.timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: expected W results are queued at issue time and
// compared when a non-bubble appears in W; stall/request cycle counts are checked per op.
module tb_mem_stage_ctrl;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        syscall;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
        logic [31:0] instr;
        logic        misaligned;
        logic        timeout;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall_m, reg_write_m, mem_to_reg_m, mem_write_m;
    logic [31:0] alu_out_m, write_data_m, instr_m;
    logic [4:0]  write_reg_m;
    logic        stall_m;
    logic        syscall_w, reg_write_w, mem_to_reg_w, misaligned_w, timeout_err;
    logic [31:0] read_data_w, alu_out_w, instr_w;
    logic [4:0]  write_reg_w;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .syscall_m    (syscall_m),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .mem_write_m  (mem_write_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m),
        .instr_m      (instr_m),
        .stall_m      (stall_m),
        .bus          (bus),
        .syscall_w    (syscall_w),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_w (mem_to_reg_w),
        .read_data_w  (read_data_w),
        .alu_out_w    (alu_out_w),
        .write_reg_w  (write_reg_w),
        .instr_w      (instr_w),
        .misaligned_w (misaligned_w),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    wb_t exp_q[$];
    wb_t obs_w;
    wb_t mon_exp;
    bit  mon_en = 1'b0;

    assign obs_w = {syscall_w, reg_write_w, mem_to_reg_w, read_data_w, alu_out_w,
                    write_reg_w, instr_w, misaligned_w, timeout_err};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Any W entry carrying a nonzero instruction word is a retired result; all else must be a clean bubble.
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_w != 32'h0) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 128'(obs_w), 128'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("wb", 128'(obs_w), 128'(mon_exp));
                end
            end else begin
                check("wb_bubble", 128'(obs_w), 128'(0));
            end
        end
    end

    // ack_at: REQ cycle (1-based) on which mem_ack is raised; 0 = never.
    task automatic issue(input logic sc, input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic [31:0] ins, input int ack_at, input logic [31:0] rdata,
                         input bit ack_idle);
        wb_t e;
        int  req_n = 0;
        int  stall_n = 0;
        int  exp_req = 0;
        int  exp_stall = 0;
        bit  done = 1'b0;

        syscall_m    = sc;
        reg_write_m  = rw;
        mem_to_reg_m = m2r;
        mem_write_m  = mw;
        alu_out_m    = alu;
        write_data_m = wd;
        write_reg_m  = wr;
        instr_m      = ins;

        e = '0;
        if (!(m2r | mw)) begin
            e = {sc, rw, m2r, 32'h0, alu, wr, ins, 1'b0, 1'b0};
        end else if (alu[1:0] != 2'b00) begin
            e.instr      = ins;
            e.misaligned = 1'b1;
        end else if (ack_at >= 1 && ack_at <= MAX_WAIT) begin
            e = {sc, rw, m2r, (m2r ? rdata : 32'h0), alu, wr, ins, 1'b0, 1'b0};
            exp_req   = ack_at;
            exp_stall = ack_at;
        end else begin
            e.instr   = ins;
            e.timeout = 1'b1;
            exp_req   = MAX_WAIT;
            exp_stall = MAX_WAIT;
        end
        exp_q.push_back(e);

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (bus.mem_req) begin
                req_n++;
                bus.mem_ack   = (req_n == ack_at);
                bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
                check("bus_addr", 128'(bus.mem_addr), 128'(alu));
                check("bus_we", 128'(bus.mem_we), 128'(mw));
                if (mw) check("bus_wdata", 128'(bus.mem_wdata), 128'(wd));
            end else begin
                bus.mem_ack   = ack_idle;
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            if (stall_m) stall_n++;
            done = !stall_m;
            @(posedge clk);
            #1;
        end
        bus.mem_ack = 1'b0;
        check("retire_bound", 128'(done), 128'(1));
        check("stall_cycles", 128'(stall_n), 128'(exp_stall));
        check("req_cycles", 128'(req_n), 128'(exp_req));
        check("req_dropped", 128'(bus.mem_req), 128'(0));
    endtask

    task automatic drive_nop();
        syscall_m    = 1'b0;
        reg_write_m  = 1'b0;
        mem_to_reg_m = 1'b0;
        mem_write_m  = 1'b0;
        alu_out_m    = '0;
        write_data_m = '0;
        write_reg_m  = '0;
        instr_m      = '0;
    endtask

    initial begin
        drive_nop();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        #8;
        check("rst_stall", 128'(stall_m), 128'(0));
        check("rst_req", 128'(bus.mem_req), 128'(0));
        check("rst_wb", 128'(obs_w), 128'(0));
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 32'h00A4_1020, 0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 5'd0, 32'h0000_000C, 0, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 32'h8C08_0100, 3, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h55, 5'd0, 32'hAC09_0204, 1, 32'h1357_9BDF, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd9, 32'h8C09_0102, 1, 32'h1111_1111, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h77, 5'd0, 32'hAC0A_0203, 1, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd10, 32'h8C0A_0300, 0, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 5'd11, 32'h0160_5820, 0, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd12, 32'h8C0C_0040, MAX_WAIT, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0048, 32'hA5A5_5A5A, 5'd0, 32'hAC0D_0048, 2, 32'h2222_2222, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(i[0], 1'b1, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 32'h1000 + i, 0, 32'h0, i[1]);
        end

        drive_nop();
        @(negedge clk);
        @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset asserted in the middle of an outstanding load.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        mem_to_reg_m = 1'b1;
        reg_write_m  = 1'b1;
        alu_out_m    = 32'h0000_0500;
        instr_m      = 32'h8C0E_0500;
        @(posedge clk);
        #1;
        check("midreq_req_up", 128'(bus.mem_req), 128'(1));
        check("midreq_stall_up", 128'(stall_m), 128'(1));
        rst_n = 1'b0;
        #1;
        check("midreq_req", 128'(bus.mem_req), 128'(0));
        check("midreq_stall", 128'(stall_m), 128'(0));
        check("midreq_wb", 128'(obs_w), 128'(0));
        drive_nop();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0777, 32'h0, 5'd3, 32'h0003_1820, 0, 32'h0, 1'b0);
        drive_nop();
        @(negedge clk);
        @(negedge clk);
        check("queue_empty_end", 128'(exp_q.size()), 128'(0));
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
